// File: rtl/ppu_pkg.sv
// Shared PPU VRAM types: VMAIN layout, prefetch FSM states, register offsets and address remap.
package ppu_pkg;

  localparam int VRAM_AW = 15;
  localparam int VRAM_DW = 16;

  localparam logic [7:0] REG_VMAIN   = 8'h15;
  localparam logic [7:0] REG_VMADDL  = 8'h16;
  localparam logic [7:0] REG_VMADDH  = 8'h17;
  localparam logic [7:0] REG_VMDATAL = 8'h18;
  localparam logic [7:0] REG_VMDATAH = 8'h19;
  localparam logic [7:0] REG_RDVRAML = 8'h39;
  localparam logic [7:0] REG_RDVRAMH = 8'h3A;

  typedef struct packed {
    logic       inc_on_hi;
    logic [2:0] rsvd;
    logic [1:0] remap;
    logic [1:0] step;
  } vmain_type;

  typedef enum logic [1:0] {IDLE, PF_ISSUE, PF_CAPTURE} vram_fsm_type;

  // Rotates the low 8/9/10 address bits so 2/4/8bpp tiles can be written linearly.
  function automatic logic [VRAM_AW-1:0] vram_remap(input logic [VRAM_AW-1:0] a,
                                                    input logic [1:0] remap);
    case (remap)
      2'b01:   return {a[14:8],  a[4:0], a[7:5]};
      2'b10:   return {a[14:9],  a[5:0], a[8:6]};
      2'b11:   return {a[14:10], a[6:0], a[9:7]};
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/vram_addr_step.sv
// VRAM word-address increment by 1/32/128, wrapping at the address width.
module vram_addr_step
  import ppu_pkg::*;
#(
  parameter int ADDR_W = VRAM_AW
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        step,
  output logic [ADDR_W-1:0] addr_next
);

  logic [ADDR_W-1:0] inc;

  always_comb begin
    case (step)
      2'b00:   inc = ADDR_W'(1);
      2'b01:   inc = ADDR_W'(32);
      default: inc = ADDR_W'(128);
    endcase
    addr_next = addr + inc;
  end

endmodule

// File: rtl/ppu_vram_port.sv
// PPU VRAM responder: render fetch path plus CPU VMAIN/VMADD/VMDATA/RDVRAM access.
// PPU_VRAM_ACCESS_GUARD_EN drops CPU writes outside blanking.
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter int ADDR_W = VRAM_AW,
  parameter int DATA_W = VRAM_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blank,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [7:0]        reg_addr,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef PPU_VRAM_ACCESS_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  vmain_type         vmain;
  vram_fsm_type      state, state_n;
  logic [ADDR_W-1:0] vmadd, vmadd_inc, vmadd_set, pf_addr, phys_vm;
  logic [DATA_W-1:0] rdbuf;

  // One-deep slot for a write that collides with PF_ISSUE
  logic              pw_vld;
  logic [ADDR_W-1:0] pw_addr;
  logic [1:0]        pw_we;
  logic [DATA_W-1:0] pw_data;

  logic wr_lo, wr_hi, wr_any, rd_lo, rd_hi, set_l, set_h, set_any;
  logic wr_inc, rd_inc, pf_start, wr_allow, drain, defer, direct;
  logic [1:0]        wr_we;
  logic [DATA_W-1:0] wr_data;

  vram_addr_step #(.ADDR_W(ADDR_W)) u_step (
    .addr      (vmadd),
    .step      (vmain.step),
    .addr_next (vmadd_inc)
  );

  always_comb begin
    wr_lo    = reg_wr && (reg_addr == REG_VMDATAL);
    wr_hi    = reg_wr && (reg_addr == REG_VMDATAH);
    wr_any   = wr_lo || wr_hi;
    rd_lo    = reg_rd && (reg_addr == REG_RDVRAML);
    rd_hi    = reg_rd && (reg_addr == REG_RDVRAMH);
    set_l    = reg_wr && (reg_addr == REG_VMADDL);
    set_h    = reg_wr && (reg_addr == REG_VMADDH);
    set_any  = set_l || set_h;
    wr_inc   = vmain.inc_on_hi ? wr_hi : wr_lo;
    rd_inc   = vmain.inc_on_hi ? rd_hi : rd_lo;
    pf_start = set_any || rd_inc;
    vmadd_set = set_l ? {vmadd[14:8], reg_wdata} : {reg_wdata[6:0], vmadd[7:0]};
    wr_allow = blank || !GUARD;
    phys_vm  = vram_remap(vmadd, vmain.remap);
    drain    = pw_vld && (state == IDLE);
    defer    = wr_any && ((state == PF_ISSUE) || drain);
    direct   = wr_any && !defer && wr_allow;
    wr_we    = {wr_hi, wr_lo};
    wr_data  = wr_hi ? {reg_wdata, 8'h00} : {8'h00, reg_wdata};
  end

  always_comb begin
    state_n = state;
    case (state)
      PF_ISSUE:   state_n = PF_CAPTURE;
      PF_CAPTURE: state_n = IDLE;
      default:    state_n = state;
    endcase
    if (pf_start) state_n = PF_ISSUE;

    mem_addr  = blank ? phys_vm : fetch_addr;
    mem_we    = 2'b00;
    mem_wdata = '0;
    if (blank && state == PF_ISSUE) mem_addr = vram_remap(pf_addr, vmain.remap);
    if (drain && wr_allow) begin
      mem_addr  = pw_addr;
      mem_we    = pw_we;
      mem_wdata = pw_data;
    end else if (direct) begin
      mem_addr  = phys_vm;
      mem_we    = wr_we;
      mem_wdata = wr_data;
    end

    reg_rdata = rd_lo ? rdbuf[7:0] : rd_hi ? rdbuf[15:8] : 8'h00;
    // Reset must also suppress the same-cycle strobe paths
    if (reset) begin
      mem_we    = 2'b00;
      reg_rdata = 8'h00;
    end
  end

  assign fetch_rdata = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      vmain   <= '0;
      vmadd   <= '0;
      pf_addr <= '0;
      rdbuf   <= '0;
      pw_vld  <= 1'b0;
      pw_addr <= '0;
      pw_we   <= 2'b00;
      pw_data <= '0;
    end else begin
      state <= state_n;
      if (reg_wr && reg_addr == REG_VMAIN) vmain <= vmain_type'(reg_wdata);
      if (set_any)               vmadd <= vmadd_set;
      else if (wr_inc || rd_inc) vmadd <= vmadd_inc;
      if (pf_start) pf_addr <= set_any ? vmadd_set : vmadd;
      if (state == PF_CAPTURE) rdbuf <= mem_rdata;
      if (defer && wr_allow) begin
        pw_vld  <= 1'b1;
        pw_addr <= phys_vm;
        pw_we   <= wr_we;
        pw_data <= wr_data;
      end else if (drain) begin
        pw_vld <= 1'b0;
      end
    end
  end

endmodule
